ivs_dma_rd_arb: RTL and testbench
=================================

Name: ivs_dma_rd_arb

Overview:
- AR-channel request arbiter directly upstream of the DMA read interface.
- Accepts three data-read requesters (dr0..dr2), round-robin arbitrates among them, and drives a registered AXI read-address beat: arid = requester index, INCR burst, 16-byte beats.
- Tracks per-ID outstanding bursts by observing R-channel last beats, and throttles each requester to MAX_OUTS outstanding bursts.

Parameters:
- MAX_OUTS, 4: maximum outstanding bursts per requester ID (1..15).
- CNT_W, 4: width of the per-ID outstanding counters; must satisfy 2^CNT_W > MAX_OUTS.

Ports:
- aclk  in  1  clock
- arst  in  1  asynchronous, active-high reset
- dr0_req  in  1  read request, level; held with base/len stable until ack
- dr0_base  in  32  byte start address, 16B aligned
- dr0_len  in  6  AXI length (beats-1)
- dr0_ack  out  1  one-cycle pulse: AR beat for dr0 accepted
- dr1_req/dr1_base/dr1_len/dr1_ack: same as dr0, for requester 1
- dr2_req/dr2_base/dr2_len/dr2_ack: same as dr0, for requester 2
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- arid  out  4  requester index 0..2
- araddr  out  32  burst address
- arlen  out  6  burst length (beats-1)
- arburst  out  2  constant 2'b01 (INCR)
- rvalid  in  1  R valid (observed only)
- rready  in  1  R ready (observed only)
- rid  in  4  R id
- rlast  in  1  R last beat
- outs_busy  out  3  bit N set when ID N outstanding count != 0

Behaviour:
- Reset (async, immediate): arvalid=0, araddr=0, arlen=0, arid=0, all counters=0, rr pointer=0, FSM=IDLE, acks=0, outs_busy=0.
- Eligibility: eligible[N] = drN_req & (cnt[N] < MAX_OUTS).
- FSM states:
  - IDLE: if any eligible, grant the first eligible at or after the rr pointer (0->1->2->0). Register araddr/arlen/arid from the winner and set arvalid=1 next cycle. Pointer becomes winner+1 mod 3. Go to ISSUE.
  - ISSUE: hold arvalid and all AR fields stable until arready. On arvalid&arready: drN_ack=1 combinationally for N=arid in that cycle, arvalid=0 next cycle, return to IDLE.
- Latency: req at cycle 0 gives arvalid at cycle 1 at the earliest. Minimum spacing between AR beats is 2 cycles.
- Requester must drop or replace its req the cycle after ack. A req still high in IDLE is treated as a new request.
- Counters:
  - cnt[arid] increments on an AR handshake.
  - cnt[rid] decrements on rvalid&rready&rlast with rid<3.
  - Same ID increment and decrement in the same cycle: value unchanged.
  - Decrement at 0 is ignored (saturates). rid>=3 is ignored.
- Requester at MAX_OUTS outstanding is skipped; the pointer still advances only on a grant.
- Request lowered during ISSUE: the AR beat still completes and ack still pulses (protocol violation by the requester; not checked).

Optional Feature:
- IVS_DMA_RD_4K_CHK_EN: adds outputs err_4k (1, sticky until reset) and err_id (2).
- A winning request crosses 4KB when base[11:0] + (len+1)*16 > 4096. Such a request is not issued: drN_ack pulses in the grant cycle, err_4k=1, err_id=N, FSM stays IDLE, and cnt is not incremented.
- Macro absent: no check, no extra ports; all requests are issued.

Decomposition:
- Package ivs_dma_pkg:
  - ID constants RD_ID_DR0/1/2
  - AXI_BURST_INCR=2'b01
  - AXI_SIZE_16B=3'b100
  - BEAT_BYTES=16
  - page size 4096
- Sub-module ivs_rr_arb3: 3-way round-robin grant with pointer update on an enable input.

Test Plan:
- dr0_req, base=0x1000, len=7, arready=1 -> arvalid at cycle 1 with araddr=0x1000, arlen=7, arid=0, arburst=01; dr0_ack pulse in cycle 1; cnt0=1.
- dr0/dr1/dr2 all held high, each dropped one cycle after its ack, then re-raised -> grant order 0,1,2,0,1,2; AR beats spaced 2 cycles apart.
- arready low 5 cycles in ISSUE -> araddr, arlen and arid stable and arvalid held; ack only in the arready cycle.
- MAX_OUTS=4, issue 4 dr1 bursts with no R traffic -> 5th dr1 request stalls while dr0 is still granted. One rvalid&rready&rlast with rid=1 -> dr1 is granted next IDLE.
- AR handshake for id2 in the same cycle as rlast with rid=2 -> cnt2 unchanged. rlast with rid=5 -> no counter change.
- arst asserted during ISSUE -> arvalid=0 and counters=0 immediately. With IVS_DMA_RD_4K_CHK_EN, base=0x0FF0, len=1 -> no arvalid, ack pulse, err_4k=1, err_id=requester index.

Source files
------------

// File: rtl/ivs_dma_pkg.sv
// Shared IDs, AXI encodings and request type for the DMA read-address arbiter.
package ivs_dma_pkg;

  localparam logic [3:0] RD_ID_DR0 = 4'd0;
  localparam logic [3:0] RD_ID_DR1 = 4'd1;
  localparam logic [3:0] RD_ID_DR2 = 4'd2;
  localparam int         NUM_RD    = 3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam int         BEAT_BYTES     = 16;
  localparam int         PAGE_BYTES     = 4096;

  typedef struct packed {
    logic [31:0] base;
    logic [5:0]  len;
  } rd_req_t;

  // True when a 16-byte-beat INCR burst starting at base_lo runs past the end of its 4KB page.
  function automatic logic crosses_4k(input logic [11:0] base_lo, input logic [5:0] len);
    logic [12:0] end_b;
    end_b = {1'b0, base_lo} + (({7'd0, len} + 13'd1) << $clog2(BEAT_BYTES));
    return end_b > 13'(PAGE_BYTES);
  endfunction

endpackage

// File: rtl/ivs_rr_arb3.sv
// Three-way round-robin grant. The search starts at the pointer, which moves past
// the winner only when en_i accepts the grant.
module ivs_rr_arb3
  import ivs_dma_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_RD-1:0] req_i,
  input  logic              en_i,
  output logic              valid_o,
  output logic [1:0]        idx_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] c1, c2;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    c1      = next_idx(ptr_q);
    c2      = next_idx(c1);
    valid_o = |req_i;
    if (req_i[ptr_q])   idx_o = ptr_q;
    else if (req_i[c1]) idx_o = c1;
    else                idx_o = c2;
    ptr_d = (en_i && valid_o) ? next_idx(idx_o) : ptr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ivs_dma_rd_arb.sv
// AR-channel arbiter for three DMA data-read requesters with per-ID outstanding throttle.
// Optional 4KB-crossing rejection is built when IVS_DMA_RD_4K_CHK_EN is defined.
module ivs_dma_rd_arb
  import ivs_dma_pkg::*;
#(
  parameter int MAX_OUTS = 4,
  parameter int CNT_W    = 4
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        dr0_req,
  input  logic [31:0] dr0_base,
  input  logic [5:0]  dr0_len,
  output logic        dr0_ack,
  input  logic        dr1_req,
  input  logic [31:0] dr1_base,
  input  logic [5:0]  dr1_len,
  output logic        dr1_ack,
  input  logic        dr2_req,
  input  logic [31:0] dr2_base,
  input  logic [5:0]  dr2_len,
  output logic        dr2_ack,
  output logic        arvalid,
  input  logic        arready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [5:0]  arlen,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  rid,
  input  logic        rlast,
  output logic [2:0]  outs_busy
`ifdef IVS_DMA_RD_4K_CHK_EN
  ,
  output logic        err_4k,
  output logic [1:0]  err_id
`endif
);

  // state | meaning
  // IDLE  | arbitrate among eligible requesters, load AR fields from the winner
  // ISSUE | arvalid high, AR fields frozen until arready
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             arvalid_q, arvalid_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [5:0]       arlen_q, arlen_d;
  logic [1:0]       arid_q, arid_d;
  logic [CNT_W-1:0] cnt_q [NUM_RD];
  logic [CNT_W-1:0] cnt_d [NUM_RD];

  rd_req_t     rq [NUM_RD];
  rd_req_t     win;
  logic [2:0]  req_vec, elig, ack_vec, rej_ack, inc, dec;
  logic        gnt_valid, reject, ar_hs, r_last_hs;
  logic [1:0]  gnt_idx;

  assign rq[0]   = '{base: dr0_base, len: dr0_len};
  assign rq[1]   = '{base: dr1_base, len: dr1_len};
  assign rq[2]   = '{base: dr2_base, len: dr2_len};
  assign req_vec = {dr2_req, dr1_req, dr0_req};

  always_comb begin
    elig = '0;
    for (int n = 0; n < NUM_RD; n++)
      elig[n] = req_vec[n] & (cnt_q[n] < CNT_W'(MAX_OUTS));
  end

  ivs_rr_arb3 u_rr (
    .clk_i   (aclk),
    .rst_i   (arst),
    .req_i   (elig),
    .en_i    (state_q == ST_IDLE),
    .valid_o (gnt_valid),
    .idx_o   (gnt_idx)
  );

  always_comb begin
    case (gnt_idx)
      2'd1:    win = rq[1];
      2'd2:    win = rq[2];
      default: win = rq[0];
    endcase
  end

`ifdef IVS_DMA_RD_4K_CHK_EN
  assign reject = (state_q == ST_IDLE) & gnt_valid & crosses_4k(win.base[11:0], win.len);
`else
  assign reject = 1'b0;
`endif

  assign rej_ack   = reject ? (3'b001 << gnt_idx) : 3'b000;
  assign ar_hs     = arvalid_q & arready;
  assign r_last_hs = rvalid & rready & rlast;

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arid_d    = arid_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid && !reject) begin
          state_d   = ST_ISSUE;
          arvalid_d = 1'b1;
          araddr_d  = win.base;
          arlen_d   = win.len;
          arid_d    = gnt_idx;
        end
      end
      default: begin
        if (arready) begin
          state_d   = ST_IDLE;
          arvalid_d = 1'b0;
        end
      end
    endcase
  end

  // A burst issued and retired for the same ID in one cycle leaves the count alone.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int n = 0; n < NUM_RD; n++) begin
      inc[n]   = ar_hs & (arid_q == 2'(n));
      dec[n]   = r_last_hs & (rid == 4'(n));
      cnt_d[n] = cnt_q[n];
      if (inc[n] && !dec[n])
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
      else if (dec[n] && !inc[n] && cnt_q[n] != '0)
        cnt_d[n] = cnt_q[n] - CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= '0;
      for (int n = 0; n < NUM_RD; n++) cnt_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arid_q    <= arid_d;
      for (int n = 0; n < NUM_RD; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  always_comb begin
    ack_vec[0] = (ar_hs & (arid_q == RD_ID_DR0[1:0])) | rej_ack[0];
    ack_vec[1] = (ar_hs & (arid_q == RD_ID_DR1[1:0])) | rej_ack[1];
    ack_vec[2] = (ar_hs & (arid_q == RD_ID_DR2[1:0])) | rej_ack[2];
    outs_busy  = '0;
    for (int n = 0; n < NUM_RD; n++) outs_busy[n] = (cnt_q[n] != '0);
  end

  assign {dr2_ack, dr1_ack, dr0_ack} = ack_vec;
  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arid    = {2'b00, arid_q};
  assign arburst = AXI_BURST_INCR;

`ifdef IVS_DMA_RD_4K_CHK_EN
  logic       err_4k_q;
  logic [1:0] err_id_q;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      err_4k_q <= 1'b0;
      err_id_q <= 2'd0;
    end else if (reject) begin
      err_4k_q <= 1'b1;
      err_id_q <= gnt_idx;
    end
  end

  assign err_4k = err_4k_q;
  assign err_id = err_id_q;
`endif

endmodule

// File: tb/tb_ivs_dma_rd_arb.sv
// Directed bench for ivs_dma_rd_arb: a per-cycle vector table plus hand sequences for
// throttling, counter corner cases, async reset and (IVS_DMA_RD_4K_CHK_EN) 4KB rejection.
module tb_ivs_dma_rd_arb;

  logic        aclk = 1'b0;
  logic        arst;
  logic        dr0_req, dr1_req, dr2_req;
  logic [31:0] dr0_base, dr1_base, dr2_base;
  logic [5:0]  dr0_len, dr1_len, dr2_len;
  logic        dr0_ack, dr1_ack, dr2_ack;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [5:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [2:0]  outs_busy;
`ifdef IVS_DMA_RD_4K_CHK_EN
  logic        err_4k;
  logic [1:0]  err_id;
`endif

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  ivs_dma_rd_arb #(.MAX_OUTS(4), .CNT_W(4)) dut (
    .aclk(aclk), .arst(arst),
    .dr0_req(dr0_req), .dr0_base(dr0_base), .dr0_len(dr0_len), .dr0_ack(dr0_ack),
    .dr1_req(dr1_req), .dr1_base(dr1_base), .dr1_len(dr1_len), .dr1_ack(dr1_ack),
    .dr2_req(dr2_req), .dr2_base(dr2_base), .dr2_len(dr2_len), .dr2_ack(dr2_ack),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rlast(rlast),
    .outs_busy(outs_busy)
`ifdef IVS_DMA_RD_4K_CHK_EN
    , .err_4k(err_4k), .err_id(err_id)
`endif
  );

  typedef struct {
    logic [2:0]  req;
    logic        ardy;
    logic        exp_av;
    logic [3:0]  exp_id;
    logic [31:0] exp_addr;
    logic [5:0]  exp_len;
    logic [2:0]  exp_ack;
    logic [2:0]  exp_busy;
  } vec_t;

  vec_t tv [22];

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] r);
    {dr2_req, dr1_req, dr0_req} = r;
  endtask

  task automatic r_beat(input logic [3:0] id_v);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; rid = id_v;
  endtask

  task automatic r_idle;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; rid = 4'd0;
  endtask

  // One full request/ack exchange for requester idx with arready high, then one quiet cycle.
  task automatic burst(input int idx);
    set_req(3'b001 << idx);
    arready = 1'b1;
    #2 chk("burst_idle_av", arvalid, 1'b0);
    tick;
    #2;
    chk("burst_av", arvalid, 1'b1);
    chk("burst_id", arid, idx);
    chk("burst_ack", {dr2_ack, dr1_ack, dr0_ack}, 3'b001 << idx);
    tick;
    set_req(3'b000);
    #2;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{3'b001, 1'b1, 1'b0, 4'd0, 32'h0,    6'd0, 3'b000, 3'b000};
    tv[1]  = '{3'b001, 1'b1, 1'b1, 4'd0, 32'h1000, 6'd7, 3'b001, 3'b000};
    tv[2]  = '{3'b000, 1'b1, 1'b0, 4'd0, 32'h0,    6'd0, 3'b000, 3'b001};
    tv[3]  = '{3'b111, 1'b1, 1'b0, 4'd0, 32'h0,    6'd0, 3'b000, 3'b001};
    tv[4]  = '{3'b111, 1'b1, 1'b1, 4'd1, 32'h2000, 6'd3, 3'b010, 3'b001};
    tv[5]  = '{3'b101, 1'b1, 1'b0, 4'd0, 32'h0,    6'd0, 3'b000, 3'b011};
    tv[6]  = '{3'b111, 1'b1, 1'b1, 4'd2, 32'h3000, 6'd0, 3'b100, 3'b011};
    tv[7]  = '{3'b011, 1'b1, 1'b0, 4'd0, 32'h0,    6'd0, 3'b000, 3'b111};
    tv[8]  = '{3'b111, 1'b1, 1'b1, 4'd0, 32'h1000, 6'd7, 3'b001, 3'b111};
    tv[9]  = '{3'b110, 1'b1, 1'b0, 4'd0, 32'h0,    6'd0, 3'b000, 3'b111};
    tv[10] = '{3'b111, 1'b1, 1'b1, 4'd1, 32'h2000, 6'd3, 3'b010, 3'b111};
    tv[11] = '{3'b101, 1'b1, 1'b0, 4'd0, 32'h0,    6'd0, 3'b000, 3'b111};
    tv[12] = '{3'b111, 1'b1, 1'b1, 4'd2, 32'h3000, 6'd0, 3'b100, 3'b111};
    tv[13] = '{3'b000, 1'b1, 1'b0, 4'd0, 32'h0,    6'd0, 3'b000, 3'b111};
    tv[14] = '{3'b010, 1'b0, 1'b0, 4'd0, 32'h0,    6'd0, 3'b000, 3'b111};
    for (int i = 15; i < 20; i++)
      tv[i] = '{3'b010, 1'b0, 1'b1, 4'd1, 32'h2000, 6'd3, 3'b000, 3'b111};
    tv[20] = '{3'b010, 1'b1, 1'b1, 4'd1, 32'h2000, 6'd3, 3'b010, 3'b111};
    tv[21] = '{3'b000, 1'b1, 1'b0, 4'd0, 32'h0,    6'd0, 3'b000, 3'b111};

    arst = 1'b1;
    set_req(3'b000);
    dr0_base = 32'h1000; dr0_len = 6'd7;
    dr1_base = 32'h2000; dr1_len = 6'd3;
    dr2_base = 32'h3000; dr2_len = 6'd0;
    arready = 1'b0;
    r_idle();

    tick;
    #2;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arlen", arlen, 6'd0);
    chk("rst_arid", arid, 4'd0);
    chk("rst_busy", outs_busy, 3'b000);
    chk("rst_ack", {dr2_ack, dr1_ack, dr0_ack}, 3'b000);
    tick;
    arst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      set_req(tv[i].req);
      arready = tv[i].ardy;
      #2;
      chk($sformatf("v%0d_arvalid", i), arvalid, tv[i].exp_av);
      chk($sformatf("v%0d_ack", i), {dr2_ack, dr1_ack, dr0_ack}, tv[i].exp_ack);
      chk($sformatf("v%0d_busy", i), outs_busy, tv[i].exp_busy);
      if (tv[i].exp_av) begin
        chk($sformatf("v%0d_arid", i), arid, tv[i].exp_id);
        chk($sformatf("v%0d_araddr", i), araddr, tv[i].exp_addr);
        chk($sformatf("v%0d_arlen", i), arlen, tv[i].exp_len);
        chk($sformatf("v%0d_arburst", i), arburst, 2'b01);
      end
      tick;
    end

    // Throttle: four dr1 bursts with no R traffic, then dr1 must wait while dr0 proceeds.
    arst = 1'b1;
    tick;
    arst = 1'b0;
    for (int i = 0; i < 4; i++) burst(1);
    #2 chk("max_busy", outs_busy, 3'b010);
    set_req(3'b011);
    tick;
    #2;
    chk("max_dr0_av", arvalid, 1'b1);
    chk("max_dr0_id", arid, 4'd0);
    chk("max_dr0_ack", {dr2_ack, dr1_ack, dr0_ack}, 3'b001);
    tick;
    set_req(3'b010);
    for (int i = 0; i < 3; i++) begin
      #2 chk("max_dr1_stalled", arvalid, 1'b0);
      tick;
    end
    r_beat(4'd1);
    #2 chk("max_release_cycle_av", arvalid, 1'b0);
    tick;
    r_idle();
    #2 chk("max_grant_cycle_av", arvalid, 1'b0);
    tick;
    #2;
    chk("max_dr1_av", arvalid, 1'b1);
    chk("max_dr1_id", arid, 4'd1);
    chk("max_dr1_ack", {dr2_ack, dr1_ack, dr0_ack}, 3'b010);
    tick;
    set_req(3'b000);
    #2 chk("max_end_busy", outs_busy, 3'b011);
    tick;

    // Same-cycle issue and retire on id2, then a stray rid=5 beat.
    burst(2);
    set_req(3'b100);
    #2;
    tick;
    r_beat(4'd2);
    #2 chk("simul_ack", {dr2_ack, dr1_ack, dr0_ack}, 3'b100);
    tick;
    r_idle();
    set_req(3'b000);
    #2 chk("simul_busy", outs_busy, 3'b111);
    tick;
    set_req(3'b010);
    r_beat(4'd5);
    #2;
    tick;
    r_idle();
    #2 chk("rid5_av_a", arvalid, 1'b0);
    tick;
    #2;
    chk("rid5_av_b", arvalid, 1'b0);
    chk("rid5_busy", outs_busy, 3'b111);
    tick;
    set_req(3'b000);
    r_beat(4'd2);
    tick;
    r_idle();
    #2 chk("cnt2_single", outs_busy, 3'b011);
    r_beat(4'd0);
    tick;
    r_idle();
    #2 chk("cnt0_drain", outs_busy, 3'b010);
    r_beat(4'd0);
    tick;
    r_idle();
    #2 chk("dec_at_zero", outs_busy, 3'b010);
    tick;

    // Async reset while a beat is waiting for arready.
    set_req(3'b001);
    arready = 1'b0;
    #2;
    tick;
    #2 chk("pre_rst_av", arvalid, 1'b1);
    arst = 1'b1;
    #1;
    chk("rst_issue_av", arvalid, 1'b0);
    chk("rst_issue_busy", outs_busy, 3'b000);
    chk("rst_issue_addr", araddr, 32'h0);
    tick;
    arst = 1'b0;
    set_req(3'b000);
    arready = 1'b1;
    #2 chk("post_rst_av", arvalid, 1'b0);
    tick;
    burst(0);
    #2 chk("post_rst_busy", outs_busy, 3'b001);
    tick;

`ifdef IVS_DMA_RD_4K_CHK_EN
    dr2_base = 32'h0000_0FF0;
    dr2_len  = 6'd1;
    set_req(3'b100);
    #2;
    chk("4k_ack", {dr2_ack, dr1_ack, dr0_ack}, 3'b100);
    chk("4k_av_grant", arvalid, 1'b0);
    tick;
    set_req(3'b000);
    #2;
    chk("4k_av_after", arvalid, 1'b0);
    chk("4k_err", err_4k, 1'b1);
    chk("4k_err_id", err_id, 2'd2);
    chk("4k_busy", outs_busy, 3'b001);
    tick;
    dr2_base = 32'h0000_0FE0;
    burst(2);
    #2;
    chk("4k_edge_busy", outs_busy, 3'b101);
    chk("4k_sticky", err_4k, 1'b1);
    tick;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
